axis_rr_arbiter: RTL and testbench

- Packet-aware round-robin arbiter that shares one AXI-Stream sink between N_SRC AXI-Stream sources, for example several Input_buffer instances feeding one DMA S2MM channel.
- Grant is locked for a whole packet, from first beat through the TLAST beat.
- Output passes through one register stage; the source index is forwarded on m_axis_id.
- MAX_BEATS guards the sink against sources that never assert TLAST.

---
 rtl/axis_arb_pkg.sv | 33 +++
 rtl/axis_rr_pick.sv | 44 ++++
 rtl/axis_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// ---------------------------------------------------------------------------
// axis_arb_pkg
//   Shared definitions for the packet-aware AXI-Stream round-robin arbiter.
//   Contents:
//     arb_state_e   - arbiter FSM states (IDLE: arbitrate, BUSY: packet lock)
//     DEF_*         - default values for N_SRC, DATA_W and MAX_BEATS
//     clog2()       - ceil(log2(value)), never less than 1, so that a
//                     1-bit field still exists for tiny parameter values
// ---------------------------------------------------------------------------
package axis_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_N_SRC     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BEATS = 256;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// ---------------------------------------------------------------------------
// axis_rr_pick
//   Purely combinational round-robin picker. Searches the request vector
//   starting at rr_ptr, then rr_ptr+1, ... wrapping modulo N_SRC, and returns
//   the first requesting index.
//   Ports:
//     req      in   N_SRC   request vector (one bit per source)
//     rr_ptr   in   IDX_W   index with the highest priority this round
//     pick     out  IDX_W   selected index (0 when any_req is low)
//     any_req  out  1       at least one request bit is set
// ---------------------------------------------------------------------------
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int  N_SRC = DEF_N_SRC,
  localparam int IDX_W = clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] pick,
  output logic             any_req
);

  // One extra bit so rr_ptr + offset cannot overflow before the wrap.
  logic [IDX_W:0] cand;

  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      // Explicit wrap: N_SRC need not be a power of two.
      if (cand >= (IDX_W+1)'(N_SRC)) begin
        cand = cand - (IDX_W+1)'(N_SRC);
      end
      if (!any_req && req[cand[IDX_W-1:0]]) begin
        any_req = 1'b1;
        pick    = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_rr_arbiter
//   Packet-aware round-robin arbiter sharing one AXI-Stream sink between
//   N_SRC AXI-Stream sources. A grant is held from the first beat through
//   TLAST (or until MAX_BEATS beats, where TLAST is forced and a sticky error
//   flag is raised). The output goes through a single register stage and
//   carries the source index on m_axis_id.
//   Ports:
//     i_clk         in   1              clock, rising edge
//     i_rst         in   1              asynchronous active-low reset
//     s_axis_data   in   N_SRC*DATA_W   source k at [k*DATA_W +: DATA_W]
//     s_axis_valid  in   N_SRC          per-source TVALID
//     s_axis_last   in   N_SRC          per-source TLAST
//     s_axis_ready  out  N_SRC          per-source TREADY (granted source only)
//     m_axis_data   out  DATA_W         registered output data
//     m_axis_valid  out  1              registered output valid
//     m_axis_last   out  1              registered TLAST (real or forced)
//     m_axis_id     out  IDX_W          source index of the output beat
//     m_axis_ready  in   1              sink TREADY
//     o_trunc_err   out  1              sticky: a packet hit MAX_BEATS
// ---------------------------------------------------------------------------
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int  N_SRC     = DEF_N_SRC,
  parameter int  DATA_W    = DEF_DATA_W,
  parameter int  MAX_BEATS = DEF_MAX_BEATS,
  localparam int IDX_W     = clog2(N_SRC),
  localparam int CNT_W     = clog2(MAX_BEATS + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_SRC*DATA_W-1:0] s_axis_data,
  input  logic [N_SRC-1:0]        s_axis_valid,
  input  logic [N_SRC-1:0]        s_axis_last,
  output logic [N_SRC-1:0]        s_axis_ready,
  output logic [DATA_W-1:0]       m_axis_data,
  output logic                    m_axis_valid,
  output logic                    m_axis_last,
  output logic [IDX_W-1:0]        m_axis_id,
  input  logic                    m_axis_ready,
  output logic                    o_trunc_err
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [IDX_W-1:0]  m_id_q, m_id_d;
  logic              trunc_q, trunc_d;

  logic [IDX_W-1:0]  pick_idx;
  logic              any_req;

  logic [DATA_W-1:0] src_data [N_SRC];
  logic              busy;
  logic              out_free;
  logic              accept;
  logic              at_limit;
  logic              end_pkt;
  logic [IDX_W-1:0]  grant_inc;

  axis_rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .req     (s_axis_valid),
    .rr_ptr  (rr_ptr_q),
    .pick    (pick_idx),
    .any_req (any_req)
  );

  // Unpack the flat source bus and gate ready onto the granted source only.
  // Ready depends combinationally on the sink so that a draining output
  // register can be refilled in the same cycle (1 beat/cycle throughput).
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_data[gi]     = s_axis_data[gi*DATA_W +: DATA_W];
      assign s_axis_ready[gi] = busy && (grant_q == IDX_W'(gi)) && out_free;
    end
  endgenerate

  assign busy     = (state_q == BUSY);
  assign out_free = !m_valid_q || m_axis_ready;
  assign accept   = busy && s_axis_valid[grant_q] && out_free;
  assign at_limit = (beat_cnt_q == CNT_W'(MAX_BEATS - 1));
  // A packet ends on a real TLAST or when the beat limit is reached.
  assign end_pkt  = accept && (s_axis_last[grant_q] || at_limit);

  // Explicit wrap for non-power-of-two N_SRC.
  assign grant_inc = (grant_q == IDX_W'(N_SRC - 1)) ? '0 : grant_q + IDX_W'(1);

  // FSM, pointer and beat counter.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    trunc_d    = trunc_q;
    case (state_q)
      IDLE: begin
        // Arbitration cycle: no data moves, the final beat of the previous
        // packet may still be waiting in the output register.
        if (any_req) begin
          grant_d = pick_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (end_pkt) begin
            state_d    = IDLE;
            rr_ptr_d   = grant_inc;
            beat_cnt_d = '0;
            if (!s_axis_last[grant_q]) begin
              trunc_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output register: load on accept, otherwise drain when the sink takes
  // the beat; payload holds while stalled.
  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_id_d    = m_id_q;
    if (accept) begin
      m_data_d  = src_data[grant_q];
      m_id_d    = grant_q;
      m_valid_d = 1'b1;
      m_last_d  = end_pkt;
    end else if (m_axis_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_id_q     <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_id_q     <= m_id_d;
      trunc_q    <= trunc_d;
    end
  end

  assign m_axis_data  = m_data_q;
  assign m_axis_valid = m_valid_q;
  assign m_axis_last  = m_last_q;
  assign m_axis_id    = m_id_q;
  assign o_trunc_err  = trunc_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_rr_arbiter
//   Directed, table-driven bench for axis_rr_arbiter (N_SRC=4, DATA_W=32,
//   MAX_BEATS=8). Each table row gives the inputs for one clock cycle, the
//   ready vector expected before the edge, and the output register contents
//   expected after it. Source k presents data {16'h0, k, d}. Hand-written
//   sequences cover power-on reset and an asynchronous reset mid-packet.
// ---------------------------------------------------------------------------
module tb_axis_rr_arbiter;

  logic         i_clk;
  logic         i_rst;
  logic [127:0] s_axis_data;
  logic [3:0]   s_axis_valid;
  logic [3:0]   s_axis_last;
  logic [3:0]   s_axis_ready;
  logic [31:0]  m_axis_data;
  logic         m_axis_valid;
  logic         m_axis_last;
  logic [1:0]   m_axis_id;
  logic         m_axis_ready;
  logic         o_trunc_err;

  int errors = 0;
  int checks = 0;

  axis_rr_arbiter #(
    .N_SRC     (4),
    .DATA_W    (32),
    .MAX_BEATS (8)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .s_axis_data  (s_axis_data),
    .s_axis_valid (s_axis_valid),
    .s_axis_last  (s_axis_last),
    .s_axis_ready (s_axis_ready),
    .m_axis_data  (m_axis_data),
    .m_axis_valid (m_axis_valid),
    .m_axis_last  (m_axis_last),
    .m_axis_id    (m_axis_id),
    .m_axis_ready (m_axis_ready),
    .o_trunc_err  (o_trunc_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [7:0]  d;
    logic        mrdy;
    logic [3:0]  e_srdy;
    logic        e_mval;
    logic [1:0]  e_id;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_trunc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [3:0] valid,
                              input logic [3:0] last, input logic [7:0] d,
                              input logic mrdy, input logic [3:0] e_srdy,
                              input logic e_mval, input logic [1:0] e_id,
                              input logic [7:0] e_d, input logic e_last,
                              input logic e_trunc);
    vec_t v;
    v.rst     = rst;
    v.valid   = valid;
    v.last    = last;
    v.d       = d;
    v.mrdy    = mrdy;
    v.e_srdy  = e_srdy;
    v.e_mval  = e_mval;
    v.e_id    = e_id;
    v.e_data  = {16'h0, 6'h0, e_id, e_d};
    v.e_last  = e_last;
    v.e_trunc = e_trunc;
    vecs.push_back(v);
  endfunction

  function automatic void chk(input string name, input int idx,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
    end
  endfunction

  task automatic drive(input logic [3:0] v, input logic [3:0] l,
                       input logic [7:0] d, input logic mr);
    s_axis_valid = v;
    s_axis_last  = l;
    m_axis_ready = mr;
    for (int k = 0; k < 4; k++) begin
      s_axis_data[k*32 +: 32] = {16'h0, 8'(k), d};
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m_valid"}, -1, 32'(m_axis_valid), 32'd0);
    chk({tag, "_m_data"},  -1, m_axis_data, 32'd0);
    chk({tag, "_m_last"},  -1, 32'(m_axis_last), 32'd0);
    chk({tag, "_m_id"},    -1, 32'(m_axis_id), 32'd0);
    chk({tag, "_trunc"},   -1, 32'(o_trunc_err), 32'd0);
    chk({tag, "_s_ready"}, -1, 32'(s_axis_ready), 32'd0);
  endtask

  initial begin
    // ---------------- table ----------------
    // A: single source, src0 4-beat packet 0x10..0x13.
    add(0, 4'b0001, 4'b0000, 8'h10, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    add(0, 4'b0001, 4'b0000, 8'h10, 1, 4'b0001, 1, 2'd0, 8'h10, 0, 0);
    add(0, 4'b0001, 4'b0000, 8'h11, 1, 4'b0001, 1, 2'd0, 8'h11, 0, 0);
    add(0, 4'b0001, 4'b0000, 8'h12, 1, 4'b0001, 1, 2'd0, 8'h12, 0, 0);
    add(0, 4'b0001, 4'b0001, 8'h13, 1, 4'b0001, 1, 2'd0, 8'h13, 1, 0);
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    // B: after reset, all sources valid, 2-beat packets: 0,1,2,3,0 with one
    // idle arbitration cycle per packet.
    for (int p = 0; p < 5; p++) begin
      add(p == 0, 4'hF, 4'h0, 8'hA0, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
      add(0, 4'hF, 4'h0, 8'hA0, 1, 4'(1 << (p % 4)), 1, 2'(p % 4), 8'hA0, 0, 0);
      add(0, 4'hF, 4'hF, 8'hA1, 1, 4'(1 << (p % 4)), 1, 2'(p % 4), 8'hA1, 1, 0);
    end
    // C: src2 with the sink stalled 3 cycles mid-packet.
    add(0, 4'b0100, 4'b0000, 8'h30, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    add(0, 4'b0100, 4'b0000, 8'h30, 1, 4'b0100, 1, 2'd2, 8'h30, 0, 0);
    add(0, 4'b0100, 4'b0000, 8'h31, 0, 4'b0000, 1, 2'd2, 8'h30, 0, 0);
    add(0, 4'b0100, 4'b0000, 8'h31, 0, 4'b0000, 1, 2'd2, 8'h30, 0, 0);
    add(0, 4'b0100, 4'b0000, 8'h31, 0, 4'b0000, 1, 2'd2, 8'h30, 0, 0);
    add(0, 4'b0100, 4'b0000, 8'h31, 1, 4'b0100, 1, 2'd2, 8'h31, 0, 0);
    add(0, 4'b0100, 4'b0100, 8'h32, 1, 4'b0100, 1, 2'd2, 8'h32, 1, 0);
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    // D: rr_ptr=3, only src1 requests -> src1 granted; it bubbles 2 cycles
    // while src3 waits; src3 is served only after src1's TLAST.
    add(0, 4'b0010, 4'b0000, 8'h40, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    add(0, 4'b1010, 4'b0000, 8'h40, 1, 4'b0010, 1, 2'd1, 8'h40, 0, 0);
    add(0, 4'b1000, 4'b0000, 8'h41, 1, 4'b0010, 0, 2'd0, 8'h00, 0, 0);
    add(0, 4'b1000, 4'b0000, 8'h41, 1, 4'b0010, 0, 2'd0, 8'h00, 0, 0);
    add(0, 4'b1010, 4'b0000, 8'h41, 1, 4'b0010, 1, 2'd1, 8'h41, 0, 0);
    add(0, 4'b1010, 4'b0010, 8'h42, 1, 4'b0010, 1, 2'd1, 8'h42, 1, 0);
    add(0, 4'b1000, 4'b0000, 8'h50, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    add(0, 4'b1000, 4'b1000, 8'h50, 1, 4'b1000, 1, 2'd3, 8'h50, 1, 0);
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    // E: src0 streams without TLAST -> forced last on beat 8, trunc flag.
    // src1 then wins (lowest priority on src0), then src0's remaining 2 beats.
    add(0, 4'b0001, 4'b0000, 8'h60, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 0);
    for (int i = 0; i < 8; i++) begin
      add(0, 4'b0001, 4'b0000, 8'(8'h60 + i), 1, 4'b0001, 1, 2'd0,
          8'(8'h60 + i), i == 7, i == 7);
    end
    add(0, 4'b0011, 4'b0010, 8'h68, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 1);
    add(0, 4'b0011, 4'b0010, 8'h68, 1, 4'b0010, 1, 2'd1, 8'h68, 1, 1);
    add(0, 4'b0001, 4'b0000, 8'h68, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 1);
    add(0, 4'b0001, 4'b0000, 8'h68, 1, 4'b0001, 1, 2'd0, 8'h68, 0, 1);
    add(0, 4'b0001, 4'b0001, 8'h69, 1, 4'b0001, 1, 2'd0, 8'h69, 1, 1);
    add(0, 4'b0000, 4'b0000, 8'h00, 1, 4'b0000, 0, 2'd0, 8'h00, 0, 1);

    // ---------------- power-on reset ----------------
    i_rst = 1'b1;
    drive(4'hF, 4'h0, 8'h00, 1'b1);
    #2 i_rst = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("por");
    i_rst = 1'b1;

    // ---------------- table run ----------------
    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].rst) begin
        i_rst = 1'b0;
        #1 i_rst = 1'b1;
      end
      drive(vecs[n].valid, vecs[n].last, vecs[n].d, vecs[n].mrdy);
      #1;
      chk("s_ready", n, 32'(s_axis_ready), 32'(vecs[n].e_srdy));
      @(posedge i_clk);
      #1;
      chk("m_valid", n, 32'(m_axis_valid), 32'(vecs[n].e_mval));
      if (vecs[n].e_mval) begin
        chk("m_data", n, m_axis_data, vecs[n].e_data);
        chk("m_last", n, 32'(m_axis_last), 32'(vecs[n].e_last));
        chk("m_id", n, 32'(m_axis_id), 32'(vecs[n].e_id));
      end
      chk("trunc", n, 32'(o_trunc_err), 32'(vecs[n].e_trunc));
      $display("step %0d: valid=%b last=%b d=%h mrdy=%b -> s_ready=%b m_valid=%b data=%h last=%b id=%0d trunc=%b",
               n, vecs[n].valid, vecs[n].last, vecs[n].d, vecs[n].mrdy, s_axis_ready,
               m_axis_valid, m_axis_data, m_axis_last, m_axis_id, o_trunc_err);
    end

    // ---------------- async reset mid-packet ----------------
    // rr_ptr=1 here; src2 alone gets granted and its first beat is loaded.
    drive(4'b0100, 4'b0000, 8'h70, 1'b1);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    chk("pre_rst_m_valid", -1, 32'(m_axis_valid), 32'd1);
    chk("pre_rst_m_id", -1, 32'(m_axis_id), 32'd2);
    drive(4'b0100, 4'b0000, 8'h71, 1'b1);
    #2 i_rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    $display("async reset mid-packet: m_valid=%b data=%h trunc=%b", m_axis_valid, m_axis_data, o_trunc_err);
    // Release between edges; all sources request -> src0 has priority.
    #1 i_rst = 1'b1;
    drive(4'hF, 4'h0, 8'h80, 1'b1);
    @(posedge i_clk);
    #1;
    chk("post_rst_arb_m_valid", -1, 32'(m_axis_valid), 32'd0);
    @(posedge i_clk);
    #1;
    chk("post_rst_m_valid", -1, 32'(m_axis_valid), 32'd1);
    chk("post_rst_m_id", -1, 32'(m_axis_id), 32'd0);
    chk("post_rst_m_data", -1, m_axis_data, 32'h0000_0080);
    $display("after reset release: m_valid=%b id=%0d data=%h", m_axis_valid, m_axis_id, m_axis_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
